// File: rtl/tts_pkg.sv
// rtl/tts_pkg.sv - shared FSM state encoding and vector constants for truth_table_scanner
package tts_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int VEC_W       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tts_state_t;

endpackage

// File: rtl/tts_settle_timer.sv
// rtl/tts_settle_timer.sv - per-vector settle counter, expire flags the last settle cycle
module tts_settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // load also fires on the expiring cycle, so the count never exceeds SETTLE_CYCLES-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire = (r_cnt == LAST_CNT);

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks 16 input vectors, captures the CUT truth table, compares to golden
// Optional mismatch capture ports (fail_idx, fail_valid) are built when TTS_MISMATCH_CAPTURE_EN is defined.
module truth_table_scanner
   import tts_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_VECTORS-1:0] expected,
   output logic [VEC_W-1:0]       vec_out,
   input  logic                   func_in,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_VECTORS-1:0] table_out
`ifdef TTS_MISMATCH_CAPTURE_EN
   ,
   output logic [VEC_W-1:0]       fail_idx,
   output logic                   fail_valid
`endif
);

   localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

   tts_state_t             r_state;
   tts_state_t             w_next_state;
   logic [VEC_W-1:0]       r_idx;
   logic [NUM_VECTORS-1:0] r_expected;
   logic [NUM_VECTORS-1:0] r_table;
   logic                   r_done;
   logic                   r_pass;
   logic                   w_expire;
   logic                   w_load;
   logic                   w_busy;
   logic                   w_accept;
   logic                   w_last;

   assign w_last   = (r_idx == LAST_IDX);
   assign w_accept = (r_state == IDLE) && start;

   tts_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (w_load),
      .expire (w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b0;
      w_load       = 1'b1;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = SETTLE;
            end
         end
         SETTLE: begin
            w_busy = 1'b1;
            w_load = w_expire;
            if (w_expire) begin
               w_next_state = SAMPLE;
            end
         end
         SAMPLE: begin
            w_busy       = 1'b1;
            w_next_state = w_last ? DONE : SETTLE;
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // golden table is latched on accept so later changes on expected cannot disturb the scan
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx      <= '0;
         r_expected <= '0;
         r_table    <= '0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_expected <= expected;
                  r_table    <= '0;
                  r_pass     <= 1'b0;
                  r_idx      <= '0;
               end
            end
            SAMPLE: begin
               r_table[r_idx] <= func_in;
               if (!w_last) begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_done <= 1'b1;
               r_pass <= (r_table == r_expected);
               r_idx  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef TTS_MISMATCH_CAPTURE_EN
   logic [VEC_W-1:0] r_fail_idx;
   logic             r_fail_valid;

   // only the first mismatching vector of a scan is recorded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fail_idx   <= '0;
         r_fail_valid <= 1'b0;
      end else if (w_accept) begin
         r_fail_idx   <= '0;
         r_fail_valid <= 1'b0;
      end else if ((r_state == SAMPLE) && !r_fail_valid && (func_in != r_expected[r_idx])) begin
         r_fail_idx   <= r_idx;
         r_fail_valid <= 1'b1;
      end
   end

   assign fail_idx   = r_fail_idx;
   assign fail_valid = r_fail_valid;
`endif

   assign vec_out   = r_idx;
   assign busy      = w_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign table_out = r_table;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for truth_table_scanner against a 0x5144 stub
module tb_truth_table_scanner;

   localparam int S        = 2;
   localparam int BUSY_CYC = 16 * (S + 1);
   localparam int SCAN     = BUSY_CYC + 1;

   typedef struct {
      logic [15:0] tbl;
      logic        pss;
      logic [3:0]  fidx;
      logic        fvld;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] expected;
   logic [3:0]  vec_out;
   wire         func_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] table_out;

   logic        start1;
   logic [15:0] expected1;
   logic [3:0]  vec_out1;
   logic        busy1;
   logic        done1;
   logic        pass1;
   logic [15:0] table_out1;
`ifdef TTS_MISMATCH_CAPTURE_EN
   logic [3:0]  fail_idx, fail_idx1;
   logic        fail_valid, fail_valid1;
`endif

   logic [15:0] tt_true = 16'h5144;
   assign #2 func_in = tt_true[vec_out];

   int n_checks = 0;
   int n_fail   = 0;

   exp_t        sb[$];
   logic        m_active   = 1'b0;
   int          m_cyc      = 0;
   logic        m_done_due = 1'b0;
   logic [15:0] hold_tbl   = '0;
   logic        hold_pass  = 1'b0;

   always #5 clk = ~clk;

   truth_table_scanner #(.SETTLE_CYCLES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .expected  (expected),
      .vec_out   (vec_out),
      .func_in   (func_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .table_out (table_out)
`ifdef TTS_MISMATCH_CAPTURE_EN
      ,
      .fail_idx   (fail_idx),
      .fail_valid (fail_valid)
`endif
   );

   truth_table_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .expected  (expected1),
      .vec_out   (vec_out1),
      .func_in   (1'b1),
      .busy      (busy1),
      .done      (done1),
      .pass      (pass1),
      .table_out (table_out1)
`ifdef TTS_MISMATCH_CAPTURE_EN
      ,
      .fail_idx   (fail_idx1),
      .fail_valid (fail_valid1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t make_exp(input logic [15:0] ex);
      exp_t        r;
      logic [15:0] d;
      d      = tt_true ^ ex;
      r.tbl  = tt_true;
      r.pss  = (d == 16'h0);
      r.fvld = (d != 16'h0);
      r.fidx = 4'h0;
      for (int k = 15; k >= 0; k--) begin
         if (d[k]) r.fidx = 4'(k);
      end
      return r;
   endfunction

   function automatic logic [3:0] exp_vec(input int c);
      int v;
      v = c / (S + 1);
      if (v > 15) v = 15;
      return 4'(v);
   endfunction

   function automatic logic [15:0] exp_partial(input int c);
      int          n;
      logic [16:0] m;
      n = c / (S + 1);
      if (n > 16) n = 16;
      m = (17'h1 << n) - 17'h1;
      return tt_true & m[15:0];
   endfunction

   // reference model: vector k is held S+1 cycles, done lands SCAN edges after accept
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active   <= 1'b0;
         m_cyc      <= 0;
         m_done_due <= 1'b0;
         sb.delete();
      end else begin
         m_done_due <= 1'b0;
         if (m_active) begin
            if (m_cyc == SCAN - 1) begin
               m_active   <= 1'b0;
               m_done_due <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
         end else if (start) begin
            m_active <= 1'b1;
            m_cyc    <= 0;
            sb.push_back(make_exp(expected));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_tbl  <= '0;
         hold_pass <= 1'b0;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_vec", vec_out, 0);
         chk("rst_table", table_out, 0);
         chk("rst_pass", pass, 0);
      end else begin
         chk("done_timing", done, m_done_due);
         chk("busy", busy, (m_active && m_cyc < BUSY_CYC) ? 1 : 0);
         chk("vec_out", vec_out, m_active ? exp_vec(m_cyc) : 4'h0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("sb_has_entry", 0, 1);
            end else begin
               e = sb.pop_front();
               chk("table_out", table_out, e.tbl);
               chk("pass", pass, e.pss);
`ifdef TTS_MISMATCH_CAPTURE_EN
               chk("fail_valid", fail_valid, e.fvld);
               if (e.fvld) chk("fail_idx", fail_idx, e.fidx);
`endif
               hold_tbl  <= e.tbl;
               hold_pass <= e.pss;
            end
         end else if (m_active) begin
            chk("partial_table", table_out, exp_partial(m_cyc));
            chk("pass_cleared", pass, 0);
         end else begin
            chk("hold_table", table_out, hold_tbl);
            chk("hold_pass", pass, hold_pass);
         end
      end
   end

   task automatic pulse_start(input int len);
      @(negedge clk);
      #1 start = 1'b1;
      repeat (len) @(negedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input bit scramble);
      int b = 0;
      while ((m_active || sb.size() != 0) && b < 300) begin
         @(negedge clk);
         #1;
         if (scramble) expected = 16'($urandom);
         b++;
      end
      chk(name, (b < 300) ? 1 : 0, 1);
   endtask

   initial begin
      int b;
      int n;
      rst       = 1'b1;
      start     = 1'b0;
      expected  = '0;
      start1    = 1'b0;
      expected1 = 16'hFFFF;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_table1", table_out1, 0);
      chk("reset_busy1", busy1, 0);
      rst = 1'b0;

      expected = 16'h5144;
      pulse_start(1);
      wait_done("wait_scan_5144", 1'b0);

      expected = 16'h5145;
      pulse_start(1);
      wait_done("wait_scan_5145", 1'b0);

      expected = 16'h5144;
      @(negedge clk);
      #1 start = 1'b1;
      repeat (2 * SCAN + 5) @(negedge clk);
      #1 start = 1'b0;
      wait_done("wait_held_start", 1'b0);

      pulse_start(1);
      b = 0;
      while (!(m_active && m_cyc == 7 * (S + 1)) && b < 300) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("wait_vec7", (b < 300) ? 1 : 0, 1);
      chk("pre_rst_vec", vec_out, 7);
      chk("pre_rst_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_table", table_out, 0);
      chk("midrst_vec", vec_out, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      pulse_start(1);
      wait_done("wait_after_rst", 1'b0);

      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         case ($urandom_range(0, 2))
            0:       expected = 16'h5144;
            1:       expected = 16'h5144 ^ (16'h1 << $urandom_range(0, 15));
            default: expected = 16'($urandom);
         endcase
         pulse_start($urandom_range(1, 3));
         wait_done("wait_random", 1'b1);
      end

      @(negedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      n = 0;
      while (!done1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("s1_done_cycle", n, 33);
      chk("s1_table", table_out1, 16'hFFFF);
      chk("s1_pass", pass1, 1);
      chk("s1_vec_idle", vec_out1, 0);

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
